// File: rtl/imem_boot_loader_if.sv
// Byte-stream intake and imem write-port bundle for the boot loader; slave = loader, master = source/imem side.
// Carries no state; all timing is defined by the loader.
// Ready/valid on the byte side, fire-and-forget strobe on the write side.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_hold;
    logic              done;
    logic              error;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: parses CNT_HI CNT_LO payload [CHK] bytes into imem words, holds the CPU until loaded. Macro: IMEM_LOADER_CHECKSUM_EN.
// Latency: wr_en pulses the cycle after the 4th byte of a word; done/error register on the deciding byte.
// Backpressure: in_ready is registered from state only; stalls never, drops permanently in DONE/ERR.
module imem_boot_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    imem_boot_loader_if.slave  bus
);
    localparam int          CNT_W   = ADDR_W - 1;
    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    typedef enum logic [2:0] {
        S_HDR_HI, S_HDR_LO, S_PAYLOAD, S_CHECK, S_DONE, S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [23:0]         word_q, word_d;
    logic [7:0]          hdr_hi_q, hdr_hi_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          chk_q, chk_d;
`endif
    logic                accept;
    logic [15:0]         n16;

    assign accept = bus.in_valid & in_ready_q;

    always_comb begin
        state_d    = state_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        count_d    = count_q;
        n_d        = n_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        hdr_hi_d   = hdr_hi_q;
        n16        = {hdr_hi_q, bus.in_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_d      = chk_q;
`endif
        case (state_q)
            S_HDR_HI: begin
                if (accept) begin
                    hdr_hi_d = bus.in_data;
                    state_d  = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (accept) begin
                    n_d = CNT_W'(n16);
                    if (n16 > DEPTH16) begin
                        state_d = S_ERR;
                    end else if (n16 == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CHECK;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ bus.in_data;
`endif
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Write pulse lands next cycle while intake continues; no bubble between words.
                        wr_en_d   = 1'b1;
                        wr_data_d = {word_q, bus.in_data};
                        wr_addr_d = {count_q[ADDR_W-3:0], 2'b00};
                        count_d   = count_q + 1'b1;
                        if (count_d == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_d = S_CHECK;
`else
                            state_d = S_DONE;
`endif
                        end
                    end else begin
                        word_d = {word_q[15:0], bus.in_data};
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    state_d = (chk_q == bus.in_data) ? S_DONE : S_ERR;
                end
            end
`endif
            default: ;
        endcase

        in_ready_d = (state_d != S_DONE) && (state_d != S_ERR);
        cpu_hold_d = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_HDR_HI;
            in_ready_q <= 1'b1;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            count_q    <= '0;
            n_q        <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            hdr_hi_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
            count_q    <= count_d;
            n_q        <= n_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            hdr_hi_q   <= hdr_hi_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.cpu_hold = cpu_hold_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader; adapts the CHK byte to IMEM_LOADER_CHECKSUM_EN.
module tb_imem_boot_loader;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic [7:0] stream_q[$];
    logic [9:0] waddr_q[$];
    logic [31:0] wdata_q[$];
    int   wr_cnt;

    imem_boot_loader_if #(.ADDR_W(10)) bus();

    imem_boot_loader #(.ADDR_W(10), .DEPTH(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port monitor; cleared while reset is held.
    always @(negedge clk) begin
        if (!rst_n) begin
            wr_cnt = 0;
            waddr_q.delete();
            wdata_q.delete();
        end else if (bus.wr_en) begin
            wr_cnt = wr_cnt + 1;
            waddr_q.push_back(bus.wr_addr);
            wdata_q.push_back(bus.wr_data);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives stream_q with in_valid held high; stalls counts cycles with in_ready low.
    task automatic drive_stream(output int stalls);
        int guard;
        stalls = 0;
        guard = 0;
        while (stream_q.size() != 0 && guard < 2000) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data = stream_q[0];
            if (bus.in_ready) void'(stream_q.pop_front());
            else stalls++;
            guard++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (stream_q.size() != 0) begin
            errors++;
            $display("FAIL stream_timeout: %0d bytes left, required 0", stream_q.size());
            stream_q.delete();
        end
    endtask

    task automatic push_scn1();
        stream_q.push_back(8'h00); stream_q.push_back(8'h01);
        stream_q.push_back(8'h20); stream_q.push_back(8'h08);
        stream_q.push_back(8'h00); stream_q.push_back(8'h05);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        repeat (2) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b want 0", bus.wr_en); end
        checks++; if (bus.wr_addr !== 10'd0) begin errors++; $display("FAIL rst_wr_addr: got %h want 0", bus.wr_addr); end
        checks++; if (bus.wr_data !== 32'd0) begin errors++; $display("FAIL rst_wr_data: got %h want 0", bus.wr_data); end
        checks++; if (bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_cpu_hold: got %b want 1", bus.cpu_hold); end
        checks++; if (bus.done !== 1'b0 || bus.error !== 1'b0) begin errors++; $display("FAIL rst_flags: done=%b error=%b want 0/0", bus.done, bus.error); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_word();
        int st;
        do_reset();
        push_scn1();
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream_q.push_back(8'h2D);
`endif
        drive_stream(st);
        repeat (2) @(negedge clk);
        checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL s1_wr_cnt: got %0d want 1", wr_cnt); end
        checks++; if (wr_cnt == 1 && (waddr_q[0] !== 10'd0 || wdata_q[0] !== 32'h20080005)) begin errors++; $display("FAIL s1_write: addr=%h data=%h want 0/20080005", waddr_q[0], wdata_q[0]); end
        checks++; if (bus.done !== 1'b1 || bus.cpu_hold !== 1'b0 || bus.error !== 1'b0) begin errors++; $display("FAIL s1_status: done=%b hold=%b error=%b want 1/0/0", bus.done, bus.cpu_hold, bus.error); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL s1_in_ready: got %b want 0", bus.in_ready); end
    endtask

    task automatic test_back_to_back();
        int st;
        do_reset();
        stream_q.push_back(8'h00); stream_q.push_back(8'h03);
        for (int w = 1; w <= 3; w++)
            for (int b = 0; b < 4; b++) stream_q.push_back(8'(w * 8'h11));
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream_q.push_back(8'h00);
`endif
        drive_stream(st);
        repeat (2) @(negedge clk);
        checks++; if (st !== 0) begin errors++; $display("FAIL s2_stalls: got %0d want 0", st); end
        checks++; if (wr_cnt !== 3) begin errors++; $display("FAIL s2_wr_cnt: got %0d want 3", wr_cnt); end
        for (int i = 0; i < 3 && i < wr_cnt; i++) begin
            checks++;
            if (waddr_q[i] !== 10'(4 * i) || wdata_q[i] !== {4{8'(8'h11 * (i + 1))}}) begin
                errors++;
                $display("FAIL s2_write%0d: addr=%h data=%h want %h/%h", i, waddr_q[i], wdata_q[i], 10'(4 * i), {4{8'(8'h11 * (i + 1))}});
            end
        end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL s2_done: got %b want 1", bus.done); end
    endtask

    task automatic test_full_depth();
        int st;
        do_reset();
        stream_q.push_back(8'h01); stream_q.push_back(8'h00);
        for (int i = 0; i < 1024; i++) stream_q.push_back(8'(i));
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream_q.push_back(8'h00);
`endif
        drive_stream(st);
        repeat (2) @(negedge clk);
        checks++; if (wr_cnt !== 256) begin errors++; $display("FAIL depth_wr_cnt: got %0d want 256", wr_cnt); end
        checks++; if (wr_cnt == 256 && (waddr_q[255] !== 10'h3FC || wdata_q[255] !== 32'hFCFDFEFF)) begin errors++; $display("FAIL depth_last: addr=%h data=%h want 3fc/fcfdfeff", waddr_q[255], wdata_q[255]); end
        checks++; if (bus.done !== 1'b1 || bus.error !== 1'b0) begin errors++; $display("FAIL depth_status: done=%b error=%b want 1/0", bus.done, bus.error); end
    endtask

    task automatic test_oversize();
        int st;
        do_reset();
        stream_q.push_back(8'h01); stream_q.push_back(8'h01);
        drive_stream(st);
        bus.in_valid = 1'b1;
        bus.in_data = 8'h55;
        repeat (4) @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.error !== 1'b1 || bus.cpu_hold !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL s3_status: error=%b hold=%b rdy=%b want 1/1/0", bus.error, bus.cpu_hold, bus.in_ready); end
        checks++; if (wr_cnt !== 0 || bus.done !== 1'b0) begin errors++; $display("FAIL s3_no_write: wr_cnt=%0d done=%b want 0/0", wr_cnt, bus.done); end
    endtask

    task automatic test_bad_checksum();
        int st;
        do_reset();
        push_scn1();
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream_q.push_back(8'h2C);
`endif
        drive_stream(st);
        repeat (2) @(negedge clk);
        checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL s4_wr_cnt: got %0d want 1", wr_cnt); end
`ifdef IMEM_LOADER_CHECKSUM_EN
        checks++; if (bus.error !== 1'b1 || bus.done !== 1'b0 || bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL s4_status: error=%b done=%b hold=%b want 1/0/1", bus.error, bus.done, bus.cpu_hold); end
`else
        checks++; if (bus.error !== 1'b0 || bus.done !== 1'b1 || bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL s4_status: error=%b done=%b hold=%b want 0/1/0", bus.error, bus.done, bus.cpu_hold); end
`endif
    endtask

    task automatic test_empty_image();
        int st;
        do_reset();
        stream_q.push_back(8'h00); stream_q.push_back(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream_q.push_back(8'h00);
`endif
        drive_stream(st);
        checks++; if (bus.done !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL s5_done: done=%b rdy=%b want 1/0", bus.done, bus.in_ready); end
        bus.in_valid = 1'b1;
        bus.in_data = 8'hAA;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (wr_cnt !== 0 || bus.done !== 1'b1 || bus.error !== 1'b0) begin errors++; $display("FAIL s5_stray: wr_cnt=%0d done=%b error=%b want 0/1/0", wr_cnt, bus.done, bus.error); end
    endtask

    task automatic test_reset_mid_load();
        int st;
        do_reset();
        stream_q.push_back(8'h00); stream_q.push_back(8'h01);
        stream_q.push_back(8'h20); stream_q.push_back(8'h08);
        drive_stream(st);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.wr_en !== 1'b0 || bus.in_ready !== 1'b1 || bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL s6_async_a: wr_en=%b rdy=%b hold=%b want 0/1/1", bus.wr_en, bus.in_ready, bus.cpu_hold); end
        do_reset();
        push_scn1();
        drive_stream(st);
        #2;
        checks++; if (bus.wr_en !== 1'b1) begin errors++; $display("FAIL s6_pulse: wr_en=%b want 1", bus.wr_en); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL s6_async_b: wr_en=%b want 0", bus.wr_en); end
        do_reset();
        push_scn1();
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream_q.push_back(8'h2D);
`endif
        drive_stream(st);
        repeat (2) @(negedge clk);
        checks++; if (wr_cnt !== 1 || bus.done !== 1'b1) begin errors++; $display("FAIL s6_reload: wr_cnt=%0d done=%b want 1/1", wr_cnt, bus.done); end
        checks++; if (wr_cnt == 1 && (waddr_q[0] !== 10'd0 || wdata_q[0] !== 32'h20080005)) begin errors++; $display("FAIL s6_write: addr=%h data=%h want 0/20080005", waddr_q[0], wdata_q[0]); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_full_depth();
        test_oversize();
        test_bad_checksum();
        test_empty_image();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
